gpio_mmio: RTL and testbench
============================

# gpio_mmio

Memory-mapped GPIO peripheral for the DE1-SoC environment, sitting on the core's data-memory bus between the core and the board pins. It consumes core stores to drive the ten red LEDs (`LEDR`) and exposes the four push buttons (`KEY`) as debounced, edge-captured, interrupt-capable inputs. It replaces direct wiring of core state to `LEDR` so firmware controls the LEDs through ordinary load/store instructions.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_0000, byte address of register 0; must be 32-byte aligned.
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronized cycles required to accept a key change; 1 to 2^20. Board builds use 1_000_000 (20 ms at 50 MHz).

Ports:
- `clk` in 1: system clock, driven from `CLOCK_50`.
- `reset_n` in 1: reset, asynchronous and active-low.
- `addr` in 32: byte address.
- `wdata` in 32: store data.
- `wstrb` in 4: byte-lane enables for `we`.
- `we` in 1: write strobe, one transfer per cycle.
- `re` in 1: read strobe.
- `rdata` out 32: read data.
- `rvalid` out 1: read data valid.
- `key_n` in 4: raw `KEY` pins, asynchronous, 0 = pressed.
- `ledr` out 10: LED drive, 1 = lit.
- `irq` out 1: level interrupt request.

## Operation
- Decode: selected when `addr[31:5] == BASE_ADDR[31:5]`. Word offset is `addr[4:2]`; `addr[1:0]` is ignored. Unselected accesses are ignored, with no `rvalid`.
- Register map (offset, access, meaning):
  - 0x00 LED_OUT, RW: bits[9:0] drive `ledr`.
  - 0x04 LED_SET, W1S: OR into LED_OUT. Reads 0.
  - 0x08 LED_CLR, W1C: clear LED_OUT bits. Reads 0.
  - 0x0C LED_TOG: XOR into LED_OUT. Reads 0.
  - 0x10 KEY_STATE, RO: debounced pressed state [3:0], 1 = pressed.
  - 0x14 KEY_EDGE, RW1C: sticky press events [3:0].
  - 0x18 IRQ_EN, RW: [3:0].
  - 0x1C: reserved. Reads 0, writes ignored.
- Byte lanes:
  - `wstrb[0]` gates bits[7:0].
  - `wstrb[1]` gates bits[9:8].
  - Lanes 2 and 3 are ignored.
  - Register bits above the implemented width read 0.
- Key path, per key:
  - 2-flop synchronizer on `key_n`, inverted so 1 = pressed.
  - Debounce counter of `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - While the synced value differs from the debounced state, the counter increments. If it would reach `DEBOUNCE_CYCLES`, the debounced state takes the synced value and the counter clears.
  - Any cycle in which synced equals debounced clears the counter. Glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- Edge capture:
  - A debounced 0→1 transition sets KEY_EDGE[k].
  - Release sets nothing.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
- `irq = |(KEY_EDGE & IRQ_EN)`, driven from registers with no combinational path from bus inputs.

## Timing
- Reset values while `reset_n` = 0:
  - `ledr` = 0, `rdata` = 0, `rvalid` = 0, `irq` = 0.
  - LED_OUT, KEY_EDGE, IRQ_EN and debounce counters = 0.
  - Debounced state = released.
  - Synchronizer flops = 1 (released).
- Reset asserted mid-debounce discards the pending change. After deassertion, a key held through reset is re-detected after the full latency and produces a KEY_EDGE event.
- Writes commit on the `clk` edge where `we` is sampled; `ledr` shows the new value the following cycle (1-cycle latency).
- Reads: `re` sampled at edge N gives `rdata`/`rvalid` valid after edge N, for one cycle. `rdata` returns to 0 when `rvalid` is low.
- Simultaneous `re` and `we` to the same register: read returns the pre-write value.
- Key latency: a clean `key_n` change at an edge appears in KEY_STATE after 2 + `DEBOUNCE_CYCLES` edges; KEY_EDGE and `irq` update in the same cycle.
- LED_TOG applied on consecutive cycles toggles each time.
- LED_SET and LED_CLR are never simultaneous (one transfer per cycle).

## Test plan
- Reset and basic write:
  - Hold `reset_n` = 0 for 10 cycles → `ledr` = 0, `rvalid` = 0, `irq` = 0.
  - Write 0x040 to 0x00 with `wstrb` = 4'b0011 → `ledr` = 10'h040 one cycle later; read 0x00 → `rdata` = 0x40 with `rvalid` for 1 cycle.
- Alias registers:
  - Starting from LED_OUT = 0x040, write SET 0x301 → 0x341.
  - Then CLR 0x041 → 0x300.
  - Then TOG 0x3FF → 0x0FF.
  - Then write 0x3FF to 0x00 with `wstrb` = 4'b0010 → 0x3FF.
- Debounce rejection:
  - `DEBOUNCE_CYCLES` = 16; pulse `key_n[2]` low for 15 cycles → KEY_STATE stays 0 and KEY_EDGE stays 0.
  - Hold `key_n[2]` low for 18+ cycles → KEY_STATE = 4'b0100 exactly 18 edges after the change, and KEY_EDGE = 4'b0100.
- Interrupt and W1C:
  - With IRQ_EN = 4'b0100 and KEY_EDGE[2] set → `irq` = 1.
  - Write 0x4 to 0x14 → KEY_EDGE = 0 and `irq` = 0 the next cycle.
  - Release the key → no new edge.
- Set/clear collision: arrange a W1C of KEY_EDGE[0] in the same cycle as a debounced press of key 0 → KEY_EDGE[0] = 1 afterwards.
- Decode and mid-debounce reset:
  - Write to 0x1C and to `BASE_ADDR` + 0x20 → no register changes, and no `rvalid` for the out-of-range read.
  - Assert `reset_n` 10 cycles into a key press → KEY_STATE = 0 after reset; the still-held key reappears 18 cycles after deassertion.

Source files
------------

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED output register with set/clear/toggle aliases, and four
// push-button inputs with synchronizer, debounce, sticky press capture and a
// level interrupt.
module gpio_mmio #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic [3:0]  key_n,
  output logic [9:0]  ledr,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value at which the next mismatching cycle completes the stable run.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OffLedOut   = 3'd0;
  localparam logic [2:0] OffLedSet   = 3'd1;
  localparam logic [2:0] OffLedClr   = 3'd2;
  localparam logic [2:0] OffLedTog   = 3'd3;
  localparam logic [2:0] OffKeyState = 3'd4;
  localparam logic [2:0] OffKeyEdge  = 3'd5;
  localparam logic [2:0] OffIrqEn    = 3'd6;

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      pressed;
  logic [3:0]      key_deb_q, key_deb_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic [3:0]      rise;
  logic [9:0]      led_q, led_d;
  logic [3:0]      key_edge_q, key_edge_d;
  logic [3:0]      irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q;

  logic            sel, wr, rd;
  logic [2:0]      off;
  logic [9:0]      mask, wbits;
  logic [31:0]     rmux;

  // Upper lanes and sub-word byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:10], wstrb[3:2], addr[1:0]};

  assign sel   = (addr[31:5] == BASE_ADDR[31:5]);
  assign off   = addr[4:2];
  assign wr    = we & sel;
  assign rd    = re & sel;
  assign mask  = {{2{wstrb[1]}}, {8{wstrb[0]}}};
  assign wbits = wdata[9:0] & mask;

  assign pressed = ~sync2_q;

  // Per-key debounce: count consecutive mismatching cycles, accept on the Nth.
  always_comb begin
    key_deb_d = key_deb_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (pressed[k] != key_deb_q[k]) begin
        if (cnt_q[k] == CntLast) begin
          key_deb_d[k] = pressed[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign rise = key_deb_d & ~key_deb_q;

  // Register writes; a debounced press overrides a same-cycle W1C of its bit.
  always_comb begin
    led_d      = led_q;
    key_edge_d = key_edge_q;
    irq_en_d   = irq_en_q;
    if (wr) begin
      case (off)
        OffLedOut:  led_d = (led_q & ~mask) | wbits;
        OffLedSet:  led_d = led_q | wbits;
        OffLedClr:  led_d = led_q & ~wbits;
        OffLedTog:  led_d = led_q ^ wbits;
        OffKeyEdge: if (wstrb[0]) key_edge_d = key_edge_q & ~wdata[3:0];
        OffIrqEn:   if (wstrb[0]) irq_en_d = wdata[3:0];
        default:    ;
      endcase
    end
    key_edge_d = key_edge_d | rise;
  end

  // irq is registered from next-state values so it tracks KEY_EDGE cycle for cycle.
  assign irq_d = |(key_edge_d & irq_en_d);

  // Read mux from current register values, so a same-cycle write is not visible.
  always_comb begin
    rmux = '0;
    case (off)
      OffLedOut:   rmux = {22'd0, led_q};
      OffKeyState: rmux = {28'd0, key_deb_q};
      OffKeyEdge:  rmux = {28'd0, key_edge_q};
      OffIrqEn:    rmux = {28'd0, irq_en_q};
      default:     rmux = '0;
    endcase
    rdata_d = rd ? rmux : 32'd0;
  end

  // Key synchronizer and debounce state; reset to released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      key_deb_q <= 4'h0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      key_deb_q <= key_deb_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Bus-visible registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      key_edge_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      led_q      <= led_d;
      key_edge_q <= key_edge_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rd;
    end
  end

  assign ledr   = led_q;
  assign irq    = irq_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: LED aliases, byte lanes, debounce latency and
// rejection, edge capture/W1C collision, interrupt, decode and mid-debounce reset.
module tb_gpio_mmio;

  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb, key_n;
  logic        we, re, rvalid, irq;
  logic [9:0]  ledr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd_d;
  logic        rd_v;

  gpio_mmio #(
    .BASE_ADDR      (Base),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .key_n  (key_n),
    .ledr   (ledr),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge; one transfer spans one rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(a, d, v);
    check_eq({tag, ".data"}, d, exp);
    check_eq({tag, ".valid"}, {31'd0, v}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; we = 1'b0; re = 1'b0; key_n = 4'hF;

    // Reset
    repeat (10) @(negedge clk);
    check_eq("rst.ledr", {22'd0, ledr}, 32'h0);
    check_eq("rst.rvalid", {31'd0, rvalid}, 32'h0);
    check_eq("rst.irq", {31'd0, irq}, 32'h0);
    check_eq("rst.rdata", rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write and read
    bus_write(Base + 32'h00, 32'h040, 4'b0011);
    check_eq("wr.ledr", {22'd0, ledr}, 32'h040);
    bus_read(Base + 32'h00, rd_d, rd_v);
    check_eq("rd.data", rd_d, 32'h40);
    check_eq("rd.valid", {31'd0, rd_v}, 32'h1);
    @(negedge clk);
    check_eq("rd.valid_drop", {31'd0, rvalid}, 32'h0);
    check_eq("rd.data_drop", rdata, 32'h0);

    // Alias registers and byte lanes
    bus_write(Base + 32'h04, 32'h301, 4'b0011);
    check_eq("set.ledr", {22'd0, ledr}, 32'h341);
    bus_write(Base + 32'h08, 32'h041, 4'b0011);
    check_eq("clr.ledr", {22'd0, ledr}, 32'h300);
    bus_write(Base + 32'h0C, 32'h3FF, 4'b0011);
    check_eq("tog.ledr", {22'd0, ledr}, 32'h0FF);
    bus_write(Base + 32'h00, 32'h3FF, 4'b0010);
    check_eq("lane1.ledr", {22'd0, ledr}, 32'h3FF);
    bus_write(Base + 32'h00, 32'h000, 4'b0010);
    check_eq("lane1_only.ledr", {22'd0, ledr}, 32'h0FF);
    bus_write(Base + 32'h00, 32'h3FF, 4'b0011);
    read_chk("set.reads0", Base + 32'h04, 32'h0);
    // Back-to-back toggles
    addr = Base + 32'h0C; wdata = 32'h003; wstrb = 4'b0001; we = 1'b1;
    @(negedge clk);
    check_eq("tog2a.ledr", {22'd0, ledr}, 32'h3FC);
    @(negedge clk);
    check_eq("tog2b.ledr", {22'd0, ledr}, 32'h3FF);
    we = 1'b0; wstrb = 4'h0;

    // Simultaneous read and write returns the old value
    addr = Base + 32'h00; wdata = 32'h155; wstrb = 4'b0011; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0; wstrb = 4'h0;
    check_eq("rw.old", rdata, 32'h3FF);
    check_eq("rw.ledr", {22'd0, ledr}, 32'h155);
    bus_write(Base + 32'h00, 32'h3FF, 4'b0011);

    // Enable key 2 interrupt
    bus_write(Base + 32'h18, 32'h4, 4'b0001);
    read_chk("irqen", Base + 32'h18, 32'h4);

    // Debounce rejection: 15-cycle glitch
    key_n[2] = 1'b0;
    repeat (15) @(negedge clk);
    key_n[2] = 1'b1;
    repeat (20) @(negedge clk);
    read_chk("glitch.state", Base + 32'h10, 32'h0);
    read_chk("glitch.edge", Base + 32'h14, 32'h0);
    check_eq("glitch.irq", {31'd0, irq}, 32'h0);

    // Held press: exactly 18 edges of latency, irq alongside
    key_n[2] = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 17) check_eq("press.irq17", {31'd0, irq}, 32'h0);
      if (i == 18) check_eq("press.irq18", {31'd0, irq}, 32'h1);
    end
    read_chk("press.state", Base + 32'h10, 32'h4);
    read_chk("press.edge", Base + 32'h14, 32'h4);

    // W1C clears edge and irq
    bus_write(Base + 32'h14, 32'h4, 4'b0001);
    check_eq("w1c.irq", {31'd0, irq}, 32'h0);
    read_chk("w1c.edge", Base + 32'h14, 32'h0);

    // Release makes no new edge
    key_n[2] = 1'b1;
    repeat (25) @(negedge clk);
    read_chk("rel.edge", Base + 32'h14, 32'h0);
    read_chk("rel.state", Base + 32'h10, 32'h0);
    check_eq("rel.irq", {31'd0, irq}, 32'h0);

    // Set/clear collision on key 0: W1C lands on the debounce edge
    key_n[0] = 1'b0;
    repeat (17) @(negedge clk);
    bus_write(Base + 32'h14, 32'h1, 4'b0001);
    read_chk("coll.edge", Base + 32'h14, 32'h1);
    bus_write(Base + 32'h14, 32'h1, 4'b0001);
    read_chk("coll.cleared", Base + 32'h14, 32'h0);
    key_n[0] = 1'b1;
    repeat (25) @(negedge clk);

    // Decode: reserved and out-of-range accesses
    bus_write(Base + 32'h1C, 32'hFFFF_FFFF, 4'hF);
    bus_write(Base + 32'h20, 32'h0, 4'hF);
    check_eq("dec.ledr", {22'd0, ledr}, 32'h3FF);
    read_chk("dec.irqen", Base + 32'h18, 32'h4);
    read_chk("dec.rsvd", Base + 32'h1C, 32'h0);
    bus_read(Base + 32'h20, rd_d, rd_v);
    check_eq("dec.oor_valid", {31'd0, rd_v}, 32'h0);
    check_eq("dec.oor_data", rd_d, 32'h0);

    // Reset in the middle of a key-3 press
    key_n[3] = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mrst.ledr", {22'd0, ledr}, 32'h0);
    reset_n = 1'b1;
    read_chk("mrst.state0", Base + 32'h10, 32'h0);
    repeat (16) @(negedge clk);
    read_chk("mrst.state17", Base + 32'h10, 32'h0);
    read_chk("mrst.state18", Base + 32'h10, 32'h8);
    read_chk("mrst.edge", Base + 32'h14, 32'h8);
    key_n[3] = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
